// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK command sequencer: op codes, FSM states and the Q-model step.
// Pairs with jk_cmd_fifo and jk_cmd_sequencer.
package jk_seq_pkg;

  // Each op value is the {J,K} pair driven during APPLY.
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic known;
    logic q;
  } model_t;

  // One clock of a JK flip-flop as seen by the sequencer's model of Q.
  function automatic model_t model_step(input logic [1:0] op, input model_t cur);
    model_t nxt;
    nxt = cur;
    case (op)
      OP_SET: begin
        nxt.known = 1'b1;
        nxt.q     = 1'b1;
      end
      OP_RESET: begin
        nxt.known = 1'b1;
        nxt.q     = 1'b0;
      end
      OP_TOGGLE: nxt.q = ~cur.q;
      default: ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK sequencer: power-of-two depth, wrapping pointers, occupancy counter.
// Push is ignored when full and pop is ignored when empty.
module jk_cmd_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op,hold} commands and plays each one onto the J/K pins of a downstream FF_JK.
// Define JK_SEQ_CHECK_EN to add the CHECK state, the Q model and the sticky err flag.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              cmd_ready,
  output logic              J,
  output logic              K,
  input  logic              Q,
  output logic              busy,
  output logic              err,
  output state_t            dbg_state
);

  localparam int CW = 2 + HOLD_W;

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on FIFO fullness, never on cmd_valid.
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_rdata;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  jk_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_hold}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cur_op;
  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // hold_cnt counts the remaining extra APPLY cycles of the active command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_op   <= OP_HOLD;
      hold_cnt <= '0;
    end else if (fifo_pop) begin
      {cur_op, hold_cnt} <= fifo_rdata;
    end else if (state == ST_APPLY && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (hold_cnt == '0) begin
`ifdef JK_SEQ_CHECK_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // J/K decode straight from state, so an async reset drops them in the same instant.
  assign {J, K}    = (state == ST_APPLY) ? cur_op : 2'b00;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef JK_SEQ_CHECK_EN
  logic exp_q;
  logic exp_known;
  logic err_q;

  // The model advances once per APPLY cycle, in step with the flip-flop's own clocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 1'b0;
      exp_known <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_APPLY) begin
        {exp_known, exp_q} <= model_step(cur_op, '{known: exp_known, q: exp_q});
      end
      if (state == ST_CHECK && exp_known && (Q != exp_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_q;
  assign unused_q = Q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer driving a behavioural FF_JK; err expectations
// follow JK_SEQ_CHECK_EN so the same bench covers both builds.
`timescale 1ns/1ps
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int HOLD_W     = 4;
`ifdef JK_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  // Scoreboard entry: {op seen on J/K, APPLY cycle count, Q after APPLY, err one cycle later}
  localparam int W = 2 + (HOLD_W + 1) + 1 + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic              cmd_ready;
  logic              J;
  logic              K;
  logic              Q;
  logic              busy;
  logic              err;
  state_t            dbg_state;

  logic ff_q;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset / downstream FF_JK ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b10:   ff_q <= 1'b1;
        2'b01:   ff_q <= 1'b0;
        2'b11:   ff_q <= ~ff_q;
        default: ;
      endcase
    end
  end

  assign Q = force_en ? force_val : ff_q;

  jk_cmd_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_hold  (cmd_hold),
    .cmd_ready (cmd_ready),
    .J         (J),
    .K         (K),
    .Q         (Q),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [1:0] op, input logic [HOLD_W-1:0] hold,
                          input logic q_after, input logic err_after);
    int waited;
    logic [HOLD_W:0] ncyc;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_hold  = hold;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("push_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      ncyc = {1'b0, hold} + 1'b1;
      exp_q.push_back({op, ncyc, q_after, err_after & CHK_EN});
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic            in_apply = 1'b0;
  logic            pend = 1'b0;
  logic            op_glitch = 1'b0;
  logic [1:0]      op_obs = 2'b00;
  logic [HOLD_W:0] n_obs = '0;
  logic            q_obs = 1'b0;
  logic [W-1:0]    mon_exp;
  logic [W-1:0]    mon_act;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_apply = 1'b0;
      pend     = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", {30'd0, op_obs}, 32'hdead);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_act = {(op_glitch ? ~op_obs : op_obs), n_obs, q_obs, err};
          chk("cmd_result", mon_act, mon_exp);
        end
      end
      if (dbg_state == ST_APPLY) begin
        if (!in_apply) begin
          in_apply  = 1'b1;
          n_obs     = 1;
          op_obs    = {J, K};
          op_glitch = 1'b0;
        end else begin
          n_obs = n_obs + 1'b1;
          if ({J, K} != op_obs) op_glitch = 1'b1;
        end
      end else if (in_apply) begin
        in_apply = 1'b0;
        q_obs    = Q;
        pend     = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_jk", {30'd0, J, K}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // SET hold=0: J/K in the second cycle after acceptance, busy clear by the fourth.
    push_cmd(OP_SET, 4'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_c1_jk", {30'd0, J, K}, 32'd0);
    chk("lat_c1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("lat_c2_jk", {30'd0, J, K}, 32'b10);
    chk("lat_c2_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_c3_jk", {30'd0, J, K}, 32'd0);
    chk("lat_c3_busy", {31'd0, busy}, {31'd0, CHK_EN});
    @(negedge clk);
    chk("lat_c4_busy", {31'd0, busy}, 32'd0);
    wait_drain("t1");

    // SET then TOGGLE hold=2: three toggles from 1 leave Q at 0.
    push_cmd(OP_SET, 4'd0, 1'b1, 1'b0);
    push_cmd(OP_TOGGLE, 4'd2, 1'b0, 1'b0);
    wait_drain("t2");

    // Long SET keeps the FSM busy while five more commands arrive; the fifth must wait.
    push_cmd(OP_SET, 4'd15, 1'b1, 1'b0);
    cyc = 0;
    while (dbg_state != ST_APPLY && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_apply_seen", {30'd0, dbg_state}, {30'd0, ST_APPLY});
    push_cmd(OP_RESET, 4'd1, 1'b0, 1'b0);
    push_cmd(OP_SET, 4'd0, 1'b1, 1'b0);
    push_cmd(OP_HOLD, 4'd2, 1'b1, 1'b0);
    push_cmd(OP_TOGGLE, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t3_full_busy", {31'd0, busy}, 32'd1);
    push_cmd(OP_TOGGLE, 4'd1, 1'b0, 1'b0);
    wait_drain("t3");

    // Q pinned low under a SET: err rises and stays through later clean commands.
    force_val = 1'b0;
    force_en  = 1'b1;
    push_cmd(OP_SET, 4'd0, 1'b0, 1'b1);
    wait_drain("t4a");
    chk("t4_err_set", {31'd0, err}, {31'd0, CHK_EN});
    force_en = 1'b0;
    push_cmd(OP_RESET, 4'd0, 1'b0, 1'b1);
    push_cmd(OP_SET, 4'd1, 1'b1, 1'b1);
    wait_drain("t4b");
    chk("t4_err_sticky", {31'd0, err}, {31'd0, CHK_EN});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // TOGGLE first after reset: model unknown, so a low Q must not raise err.
    force_val = 1'b0;
    force_en  = 1'b1;
    push_cmd(OP_TOGGLE, 4'd0, 1'b0, 1'b0);
    wait_drain("t5");
    chk("t5_err", {31'd0, err}, 32'd0);
    force_en = 1'b0;

    // Reset in the middle of a hold=15 APPLY aborts it and discards queued commands.
    push_cmd(OP_SET, 4'd15, 1'b1, 1'b0);
    push_cmd(OP_RESET, 4'd0, 1'b0, 1'b0);
    push_cmd(OP_SET, 4'd0, 1'b1, 1'b0);
    cyc = 0;
    while (!J && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("t6_mid_apply_j", {31'd0, J}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_abort_jk", {30'd0, J, K}, 32'd0);
    chk("t6_abort_busy", {31'd0, busy}, 32'd0);
    chk("t6_abort_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_fifo_empty_busy", {31'd0, busy}, 32'd0);
    chk("t6_fifo_empty_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    push_cmd(OP_SET, 4'd0, 1'b1, 1'b0);
    wait_drain("t6");
    chk("final_err", {31'd0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
